inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of core32 decode. Owns the PC,
//  drives the instruction-memory request/ack/response handshake, and buffers
//  returned instructions in a small FIFO. Presents them to core32 decode with
//  valid/ready. Accepts PC redirects (branch/jump) from the execute stage.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value after reset or reset_pc
//  FIFO_DEPTH    2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high reset of all state
//  reset_pc         in   1   sync: PC<=RESET_VECTOR, flush FIFO, drop in-flight rsp
//  redirect_valid   in   1   sync: load redirect_pc, flush FIFO, drop in-flight rsp
//  redirect_pc      in   32  redirect target; bits [1:0] ignored (forced 0)
//  inst_mem_req     out  1   request valid to instruction memory
//  inst_mem_addr    out  32  word-aligned fetch address
//  inst_mem_req_ack in   1   memory accepted request this cycle
//  inst_mem_rsp     in   1   inst_mem_rdata valid this cycle
//  inst_mem_rdata   in   32  returned instruction word
//  fetch_valid      out  1   FIFO head valid to decode
//  fetch_inst       out  32  FIFO head instruction
//  fetch_pc         out  32  PC of FIFO head instruction
//  fetch_ready      in   1   decode consumes head when fetch_valid && fetch_ready
// BEHAVIOUR
//  Reset (async): pc=RESET_VECTOR, state=IDLE, FIFO empty, drop=0;
//   inst_mem_req=0, inst_mem_addr=RESET_VECTOR, fetch_valid=0,
//   fetch_inst=0, fetch_pc=0.
//  Maximum one outstanding request. Credit = FIFO free entries minus
//   in-flight count. Issue only if credit>0.
//  FSM:
//   IDLE: if credit>0 and no flush this cycle -> REQ (req asserted next cycle).
//   REQ:  inst_mem_req=1, inst_mem_addr=pc held stable until ack.
//         On ack: pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), -> WAIT.
//   WAIT: on inst_mem_rsp: if drop=0, push {pc_of_req, rdata} to FIFO.
//         If drop=1, discard and clear drop. Then -> REQ if credit>0, else IDLE.
//   Ack and rsp are never the same cycle for one request. Min fetch
//   latency is req->ack->rsp->FIFO->fetch_valid, registered push.
//  Flush (reset_pc or redirect_valid; reset_pc wins if both):
//   pc<=target; FIFO emptied same edge; fetch_valid=0 next cycle.
//   In REQ: req stays asserted with old addr until ack (no retraction).
//    Set drop=1; after ack -> WAIT; pc is not incremented; target is kept.
//   In WAIT: set drop=1 and discard the pending rsp. If rsp arrives in the
//    same cycle as flush, it is discarded.
//   In IDLE: next request uses target.
//   A flush in the same cycle as a decode pop: the pop is ignored, and the
//   FIFO ends empty.
//   A second flush before a dropped rsp returns keeps drop=1 and updates pc.
//  FIFO:
//   Push and pop in the same cycle when full is legal (credit logic prevents
//   overflow). Pop when empty has no effect. Head outputs are registered and
//   stable while fetch_valid && !fetch_ready.
//  The first non-dropped push after a flush carries fetch_pc=target.
// TESTING
//  1 Reset release, mem acks 1 cycle after req, rsp 1 cycle after ack,
//    fetch_ready=1 -> addrs 0,4,8 in order; fetch_pc/inst match the memory model.
//  2 fetch_ready=0 for 10 cycles -> exactly FIFO_DEPTH instrs buffered,
//    inst_mem_req stays 0; then ready=1 -> resumes, with no loss or duplication.
//  3 redirect_valid to 32'h100 while in WAIT -> old rsp discarded,
//    next inst_mem_addr=32'h100, first fetch_pc=32'h100.
//  4 redirect during REQ with ack delayed 5 cycles -> addr held stable until
//    ack, its rsp dropped, next req addr=target, pc not advanced past target.
//  5 Start pc=32'hFFFF_FFF8 via redirect -> fetches FFF8, FFFC, then 0000_0000.
//  6 Assert async reset mid-WAIT (off clock edge) -> outputs hit reset values
//    immediately; a late rsp after release is not pushed; fetch restarts at
//    RESET_VECTOR.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding request/ack/rsp
// handshake to instruction memory and buffers returned words for core32 decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reset_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_mem_req,
    output logic [31:0] inst_mem_addr,
    input  logic        inst_mem_req_ack,
    input  logic        inst_mem_rsp,
    input  logic [31:0] inst_mem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             req_q, req_d;
    logic             drop_q, drop_d;

    logic [XLEN-1:0]  buf_inst_q [FIFO_DEPTH];
    logic [XLEN-1:0]  buf_inst_d [FIFO_DEPTH];
    logic [XLEN-1:0]  buf_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0]  buf_pc_d   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fetch_valid_q, fetch_valid_d;
    logic [XLEN-1:0]  fetch_inst_q, fetch_inst_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;

    logic             flush;
    logic [XLEN-1:0]  target;
    logic             push;
    logic             pop;
    logic             credit_ok;

    // Next-state logic for PC, request FSM, buffer and registered head
    always_comb begin
        flush  = reset_pc | redirect_valid;
        target = reset_pc ? RESET_VECTOR : (redirect_pc & 32'hFFFF_FFFC);
        push   = (state_q == ST_WAIT) && inst_mem_rsp && !drop_q && !flush;
        pop    = fetch_valid_q && fetch_ready && !flush;

        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_inst_d[wr_ptr_q] = inst_mem_rdata;
                buf_pc_d[wr_ptr_q]   = addr_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Issue decisions are only taken with nothing in flight, so credit is the free space left
        credit_ok = (count_d < CNT_W'(FIFO_DEPTH));

        state_d = state_q;
        pc_d    = flush ? target : pc_q;
        drop_d  = drop_q;
        addr_d  = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (!flush && credit_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (inst_mem_req_ack) begin
                    state_d = ST_WAIT;
                    if (!flush && !drop_q) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_mem_rsp) begin
                    drop_d  = 1'b0;
                    state_d = credit_ok ? ST_REQ : ST_IDLE;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Address is captured on entry to REQ and held until the ack
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            addr_d = pc_d;
        end
        req_d = (state_d == ST_REQ);

        fetch_valid_d = (count_d != '0);
        fetch_inst_d  = fetch_inst_q;
        fetch_pc_d    = fetch_pc_q;
        if (count_d != '0) begin
            fetch_inst_d = buf_inst_d[rd_ptr_d];
            fetch_pc_d   = buf_pc_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            addr_q        <= RESET_VECTOR;
            req_q         <= 1'b0;
            drop_q        <= 1'b0;
            buf_inst_q    <= '{default: '0};
            buf_pc_q      <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= '0;
            fetch_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            req_q         <= req_d;
            drop_q        <= drop_d;
            buf_inst_q    <= buf_inst_d;
            buf_pc_q      <= buf_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

    assign inst_mem_req  = req_q;
    assign inst_mem_addr = addr_q;
    assign fetch_valid   = fetch_valid_q;
    assign fetch_inst    = fetch_inst_q;
    assign fetch_pc      = fetch_pc_q;

endmodule
